bcd_seq_conv: RTL and testbench

//   Sequential binary-to-BCD converter (shift-and-add-3, one shift step per clock).

---
 rtl/bcd_seq_conv_if.sv | 24 ++
 rtl/bcd_seq_conv.sv | 132 +++++++++++++
 tb/tb_bcd_seq_conv.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_seq_conv_if.sv
// Handshake bundle for the sequential binary-to-BCD converter: binary operand in,
// packed BCD result out, plus the conversion-in-progress flag.
interface bcd_seq_conv_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic                  i_valid;
   logic                  o_ready;
   logic [WIDTH-1:0]      i_bin;
   logic                  o_valid;
   logic                  i_ready;
   logic [4*DIGITS-1:0]   o_bcd;
   logic                  o_busy;

   modport master (
      output i_valid, i_bin, i_ready,
      input  o_ready, o_valid, o_bcd, o_busy
   );

   modport slave (
      input  i_valid, i_bin, i_ready,
      output o_ready, o_valid, o_bcd, o_busy
   );
endinterface

// File: rtl/bcd_seq_conv.sv
// Sequential binary-to-BCD converter: one shift-and-add-3 step per clock,
// valid/ready on both the binary operand and the packed BCD result.
module bcd_seq_conv #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   bcd_seq_conv_if.slave  bus
);

   localparam int BW = 4 * DIGITS;
   localparam int SW = BW + WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic longint unsigned pow10_f(input int n);
      longint unsigned p;
      p = 64'd1;
      for (int i = 0; i < n; i++) begin
         p = p * 64'd10;
      end
      return p;
   endfunction

   // Correct every digit that would overflow past 9 once doubled; no carry between digits.
   function automatic logic [BW-1:0] add3_f(input logic [BW-1:0] b);
      logic [BW-1:0] r;
      r = b;
      for (int d = 0; d < DIGITS; d++) begin
         if (b[4*d +: 4] >= 4'd5) begin
            r[4*d +: 4] = b[4*d +: 4] + 4'd3;
         end else begin
            r[4*d +: 4] = b[4*d +: 4];
         end
      end
      return r;
   endfunction

   generate
      if (pow10_f(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_digits_check
         $error("bcd_seq_conv: DIGITS too small to hold 2**WIDTH-1");
      end
   endgenerate

   state_t          state_r, state_s;
   logic [SW-1:0]   shreg_r, shreg_s;
   logic [CW-1:0]   cnt_r, cnt_s;
   logic [BW-1:0]   bcd_r, bcd_s;
   logic [BW-1:0]   bcd_corr_s;
   logic            o_ready_r, o_valid_r, o_busy_r;
   logic            o_valid_s;

   // Next-state, working register and result capture.
   always_comb begin
      state_s    = state_r;
      shreg_s    = shreg_r;
      cnt_s      = cnt_r;
      bcd_s      = bcd_r;
      o_valid_s  = 1'b0;
      bcd_corr_s = add3_f(shreg_r[SW-1 -: BW]);
      case (state_r)
         IDLE: begin
            if (bus.i_valid) begin
               shreg_s = {{BW{1'b0}}, bus.i_bin};
               cnt_s   = CW'(WIDTH);
               state_s = SHIFT;
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            shreg_s = SW'({bcd_corr_s, shreg_r[WIDTH-1:0]} << 1'b1);
            cnt_s   = cnt_r - CW'(1);
            if (cnt_r == CW'(1)) begin
               state_s = DONE;
            end else begin
               state_s = SHIFT;
            end
         end
         DONE: begin
            // First DONE cycle latches the result into the output register.
            if (!o_valid_r) begin
               bcd_s = shreg_r[SW-1 -: BW];
            end else begin
               bcd_s = bcd_r;
            end
            o_valid_s = !(o_valid_r && bus.i_ready);
            if (o_valid_r && bus.i_ready) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, datapath and registered handshake outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r   <= IDLE;
         shreg_r   <= '0;
         cnt_r     <= '0;
         bcd_r     <= '0;
         o_ready_r <= 1'b1;
         o_valid_r <= 1'b0;
         o_busy_r  <= 1'b0;
      end else begin
         state_r   <= state_s;
         shreg_r   <= shreg_s;
         cnt_r     <= cnt_s;
         bcd_r     <= bcd_s;
         o_ready_r <= (state_s == IDLE);
         o_valid_r <= o_valid_s;
         o_busy_r  <= (state_s == SHIFT);
      end
   end

   assign bus.o_ready = o_ready_r;
   assign bus.o_valid = o_valid_r;
   assign bus.o_busy  = o_busy_r;
   assign bus.o_bcd   = bcd_r;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Randomized bench for bcd_seq_conv: results compared with a decimal-digit
// reference computed by plain division, plus directed handshake/reset cases.
module tb_bcd_seq_conv;
   localparam int WIDTH  = 8;
   localparam int DIGITS = 3;
   localparam int BW     = 4 * DIGITS;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_mis = 0;

   always #5 clk = ~clk;

   bcd_seq_conv_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

   bcd_seq_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [BW-1:0] ref_bcd(input int v);
      int            x;
      logic [BW-1:0] r;
      x = v;
      r = '0;
      for (int d = 0; d < DIGITS; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [WIDTH-1:0] v);
      int n;
      n = 0;
      bus.i_valid = 1'b1;
      bus.i_bin   = v;
      while (!bus.o_ready && n < 100) begin
         tick();
         n++;
      end
      check("accept_ready", 32'(bus.o_ready), 32'd1);
      tick();
      bus.i_valid = 1'b0;
      bus.i_bin   = WIDTH'($urandom);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!bus.o_valid && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   task automatic drain(input logic [BW-1:0] exp, input string tag, input bit stall);
      int n;
      n = 0;
      while (n < 200) begin
         bus.i_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus.o_valid && bus.i_ready) break;
         tick();
         n++;
      end
      check({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
      check(tag, 32'(bus.o_bcd), 32'(exp));
      tick();
      bus.i_ready = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat;
      logic [WIDTH-1:0] known [3];
      known[0] = 8'd0;
      known[1] = 8'd99;
      known[2] = 8'd100;

      bus.i_valid = 1'b0;
      bus.i_bin   = '0;
      bus.i_ready = 1'b0;
      #12;
      check("rst_ready", 32'(bus.o_ready), 32'd1);
      check("rst_valid", 32'(bus.o_valid), 32'd0);
      check("rst_busy",  32'(bus.o_busy),  32'd0);
      check("rst_bcd",   32'(bus.o_bcd),   32'd0);
      rst_n = 1'b1;
      tick();

      // 255 with consumer always ready: latency and drain behaviour
      accept(8'd255);
      check("busy_255", 32'(bus.o_busy), 32'd1);
      wait_valid(lat);
      check("lat_255", 32'(lat), 32'(WIDTH + 1));
      drain(ref_bcd(255), "bcd_255", 1'b0);
      check("post_valid", 32'(bus.o_valid), 32'd0);
      check("post_ready", 32'(bus.o_ready), 32'd1);
      check("bcd_retain", 32'(bus.o_bcd), 32'h255);

      foreach (known[i]) begin
         accept(known[i]);
         wait_valid(lat);
         drain(ref_bcd(int'(known[i])), "bcd_known", 1'b0);
      end

      // 137 held under back-pressure
      accept(8'd137);
      wait_valid(lat);
      bus.i_ready = 1'b0;
      repeat (5) begin
         check("hold_bcd",   32'(bus.o_bcd),   32'h137);
         check("hold_ready", 32'(bus.o_ready), 32'd0);
         check("hold_valid", 32'(bus.o_valid), 32'd1);
         tick();
      end
      bus.i_ready = 1'b1;
      tick();
      bus.i_ready = 1'b0;
      check("drop_valid", 32'(bus.o_valid), 32'd0);

      // New operand offered mid-conversion must be ignored
      accept(8'd200);
      bus.i_valid = 1'b1;
      bus.i_bin   = 8'd42;
      repeat (4) tick();
      bus.i_valid = 1'b0;
      wait_valid(lat);
      drain(ref_bcd(200), "bcd_200", 1'b0);
      repeat (3) tick();
      check("no_extra_valid", 32'(bus.o_valid), 32'd0);
      check("no_extra_busy",  32'(bus.o_busy),  32'd0);

      // Asynchronous reset in the middle of a conversion
      accept(8'd255);
      repeat (4) tick();
      check("mid_busy", 32'(bus.o_busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_busy",  32'(bus.o_busy),  32'd0);
      check("arst_valid", 32'(bus.o_valid), 32'd0);
      check("arst_ready", 32'(bus.o_ready), 32'd1);
      #3;
      rst_n = 1'b1;
      tick();
      accept(8'd7);
      wait_valid(lat);
      drain(ref_bcd(7), "bcd_7", 1'b0);

      // Full operand range with random gaps and consumer stalls
      for (int v = 0; v < (1 << WIDTH); v++) begin
         repeat ($urandom_range(0, 3)) tick();
         accept(WIDTH'(v));
         wait_valid(lat);
         check("exh_lat", 32'(lat), 32'(WIDTH + 1));
         drain(ref_bcd(v), "exh_bcd", 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
